// File: rtl/ipv4_checksum_calculator.sv
// ipv4_checksum_calculator: two-stage pipelined IPv4 header checksum (checksum word taken as zero)
module ipv4_checksum_calculator (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        IN_VALID,
    input  logic [7:0]  VERSION,
    input  logic [7:0]  SERVICE_TYPE,
    input  logic [15:0] LENGTH,
    input  logic [15:0] IDENTIFICATION,
    input  logic [15:0] FLAGS_AND_FRAGMENT,
    input  logic [7:0]  TTL,
    input  logic [7:0]  PROTOCOL,
    input  logic [31:0] SRC_IP_ADDRESS,
    input  logic [31:0] DST_IP_ADDRESS,
    output logic        OUT_VALID,
    output logic [15:0] CHECKSUM
);
    logic [19:0] sum_d, sum_q;
    logic        v1_d, v1_q;
    logic [15:0] checksum_d, checksum_q;
    logic        out_valid_d, out_valid_q;
    logic [16:0] f1;
    logic [15:0] f2;
    always_comb begin
        sum_d = 20'({VERSION, SERVICE_TYPE}) + 20'(LENGTH) + 20'(IDENTIFICATION)
              + 20'(FLAGS_AND_FRAGMENT) + 20'({TTL, PROTOCOL})
              + 20'(SRC_IP_ADDRESS[31:16]) + 20'(SRC_IP_ADDRESS[15:0])
              + 20'(DST_IP_ADDRESS[31:16]) + 20'(DST_IP_ADDRESS[15:0]);
        v1_d = IN_VALID;
        // second fold cannot overflow: a carry out of f1 leaves f1[15:0] <= 7
        f1 = {1'b0, sum_q[15:0]} + 17'(sum_q[19:16]);
        f2 = f1[15:0] + 16'(f1[16]);
        checksum_d = v1_q ? ~f2 : checksum_q;
        out_valid_d = v1_q;
    end
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sum_q <= '0;
            v1_q <= 1'b0;
            checksum_q <= '0;
            out_valid_q <= 1'b0;
        end else begin
            sum_q <= sum_d;
            v1_q <= v1_d;
            checksum_q <= checksum_d;
            out_valid_q <= out_valid_d;
        end
    end
    assign CHECKSUM = checksum_q;
    assign OUT_VALID = out_valid_q;
endmodule

// File: tb/tb_ipv4_checksum_calculator.sv
// tb_ipv4_checksum_calculator: directed vectors with a queued scoreboard and an independent output monitor
module tb_ipv4_checksum_calculator;
    logic        CLK, RST_N, IN_VALID;
    logic [7:0]  VERSION, SERVICE_TYPE, TTL, PROTOCOL;
    logic [15:0] LENGTH, IDENTIFICATION, FLAGS_AND_FRAGMENT;
    logic [31:0] SRC_IP_ADDRESS, DST_IP_ADDRESS;
    logic        OUT_VALID;
    logic [15:0] CHECKSUM;

    typedef struct {
        int          cyc;
        logic [15:0] val;
    } exp_t;
    exp_t sb[$];
    int cyc = 0;
    int passed = 0;
    int total = 0;

    ipv4_checksum_calculator dut (
        .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID),
        .VERSION(VERSION), .SERVICE_TYPE(SERVICE_TYPE), .LENGTH(LENGTH),
        .IDENTIFICATION(IDENTIFICATION), .FLAGS_AND_FRAGMENT(FLAGS_AND_FRAGMENT),
        .TTL(TTL), .PROTOCOL(PROTOCOL), .SRC_IP_ADDRESS(SRC_IP_ADDRESS),
        .DST_IP_ADDRESS(DST_IP_ADDRESS), .OUT_VALID(OUT_VALID), .CHECKSUM(CHECKSUM)
    );

    initial begin
        CLK = 0;
        forever #5 CLK = ~CLK;
    end

    initial forever begin
        @(posedge CLK);
        cyc++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // monitor: a pulse must match the oldest expectation both in value and in cycle
    initial forever begin
        @(negedge CLK);
        while (sb.size() != 0 && sb[0].cyc < cyc) begin
            check("missing_out_valid", 32'(sb[0].cyc), 32'(cyc));
            void'(sb.pop_front());
        end
        if (OUT_VALID === 1'b1) begin
            if (sb.size() == 0) check("unexpected_out_valid", 1, 0);
            else begin
                exp_t e;
                e = sb.pop_front();
                check("checksum", 32'(CHECKSUM), 32'(e.val));
                check("latency_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic fields(input logic [7:0] v, s, input logic [15:0] l, id, ff,
                          input logic [7:0] t, p, input logic [31:0] src, dst);
        VERSION = v; SERVICE_TYPE = s; LENGTH = l; IDENTIFICATION = id;
        FLAGS_AND_FRAGMENT = ff; TTL = t; PROTOCOL = p;
        SRC_IP_ADDRESS = src; DST_IP_ADDRESS = dst;
    endtask

    task automatic send_std(input logic [15:0] e, input bit push);
        @(posedge CLK); #1;
        fields(8'h45, 8'h00, 16'h0073, 16'h0000, 16'h4000, 8'h40, 8'h11, 32'hC0A80001, 32'hC0A800C7);
        IN_VALID = 1;
        if (push) sb.push_back('{cyc + 2, e});
    endtask

    task automatic send_second();
        @(posedge CLK); #1;
        fields(8'h45, 8'h00, 16'h002E, 16'h0000, 16'h0000, 8'h80, 8'h00, 32'h020B0101, 32'h010B0101);
        IN_VALID = 1;
        sb.push_back('{cyc + 2, 16'h35B9});
    endtask

    task automatic send_ones();
        @(posedge CLK); #1;
        fields(8'hFF, 8'hFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 8'hFF, 8'hFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
        IN_VALID = 1;
        sb.push_back('{cyc + 2, 16'h0000});
    endtask

    task automatic send_raw(input logic [15:0] id, input logic [15:0] e);
        @(posedge CLK); #1;
        fields(8'hFF, 8'hFF, 16'hFFFF, id, 16'h0000, 8'h00, 8'h00, 32'h0, 32'h0);
        IN_VALID = 1;
        sb.push_back('{cyc + 2, e});
    endtask

    task automatic send_zero();
        @(posedge CLK); #1;
        fields(8'h00, 8'h00, 16'h0, 16'h0, 16'h0, 8'h00, 8'h00, 32'h0, 32'h0);
        IN_VALID = 1;
        sb.push_back('{cyc + 2, 16'hFFFF});
    endtask

    task automatic idle(input int n);
        @(posedge CLK); #1;
        IN_VALID = 0;
        repeat (n - 1) @(posedge CLK);
    endtask

    initial begin
        RST_N = 0;
        IN_VALID = 0;
        fields(8'h00, 8'h00, 16'h0, 16'h0, 16'h0, 8'h00, 8'h00, 32'h0, 32'h0);
        repeat (3) @(posedge CLK);
        #1 RST_N = 1;
        repeat (3) begin
            @(negedge CLK);
            check("reset_checksum", 32'(CHECKSUM), 32'h0);
            check("reset_out_valid", 32'(OUT_VALID), 32'h0);
        end
        send_std(16'hB861, 1); idle(3);
        send_second();         idle(3);
        send_ones();           idle(3);
        send_zero();           idle(3);
        // low sum 0xFFFF + 0x1 carries out of the first fold: 0x1FFFF -> ~0x0001
        send_raw(16'h0001, 16'hFFFE); idle(3);
        send_raw(16'h0002, 16'hFFFD); idle(3);
        send_std(16'hB861, 1);
        send_second();
        send_ones();
        repeat (6) begin
            @(posedge CLK); #1;
            IN_VALID = 0;
            fields(8'($urandom), 8'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                   8'($urandom), 8'($urandom), $urandom, $urandom);
        end
        repeat (4) begin
            @(posedge CLK); #1;
            fields(8'($urandom), 8'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                   8'($urandom), 8'($urandom), $urandom, $urandom);
            @(negedge CLK);
            check("hold_checksum", 32'(CHECKSUM), 32'h0);
            check("hold_out_valid", 32'(OUT_VALID), 32'h0);
        end
        // asynchronous reset asserted between edges while a result is on the output
        send_std(16'hB861, 1);
        @(posedge CLK); #1 IN_VALID = 0;
        @(posedge CLK); #7 RST_N = 0;
        #1;
        check("async_reset_checksum", 32'(CHECKSUM), 32'h0);
        check("async_reset_out_valid", 32'(OUT_VALID), 32'h0);
        @(posedge CLK); #1 RST_N = 1;
        // header in flight when reset hits must never emerge
        send_std(16'hB861, 0);
        @(posedge CLK); #1 IN_VALID = 0; RST_N = 0;
        @(posedge CLK); #1 RST_N = 1;
        repeat (4) begin
            @(negedge CLK);
            check("midreset_checksum", 32'(CHECKSUM), 32'h0);
            check("midreset_out_valid", 32'(OUT_VALID), 32'h0);
        end
        for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge CLK);
        check("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
